// File: rtl/fir_out_decim.sv
// Integrate-and-dump decimator (factor 2^DEC_LOG2) feeding a small valid/ready output FIFO.
// Build option: define FIR_OUT_DECIM_ROUND_EN for round-half-up averaging, otherwise truncate.
module fir_out_decim #(
   parameter int DW         = 16,
   parameter int DEC_LOG2   = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   input  logic [DW-1:0]                 din,
   input  logic                          clr,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DW-1:0]                 dout,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          ovf
);
   localparam int AW = DW + DEC_LOG2;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;
`ifdef FIR_OUT_DECIM_ROUND_EN
   localparam logic [AW-1:0] RND = AW'(1 << (DEC_LOG2 - 1));
`else
   localparam logic [AW-1:0] RND = '0;
`endif

   logic [AW-1:0]       acc_q, acc_d;
   logic [DEC_LOG2-1:0] cnt_q, cnt_d;
   logic [PW-1:0]       wr_q, wr_d, rd_q, rd_d;
   logic [LW-1:0]       lvl_q, lvl_d;
   logic                ovf_q, ovf_d;
   logic [DW-1:0]       mem [FIFO_DEPTH];

   logic [AW-1:0] acc_nx, sum;
   logic          blk_done, full, pop, push, wr_en;

   // A full block of DEC samples cannot exceed AW bits even with the rounding term added.
   always_comb begin
      acc_nx   = acc_q + AW'(din);
      sum      = acc_nx + RND;
      blk_done = in_valid && (cnt_q == '1);
      full     = (lvl_q == LW'(FIFO_DEPTH));
      pop      = (lvl_q != '0) && out_ready;
      push     = blk_done && (!full || pop);
      wr_en    = push && !clr;

      acc_d = acc_q;
      cnt_d = cnt_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      lvl_d = lvl_q;
      ovf_d = ovf_q;

      if (clr) begin
         acc_d = '0;
         cnt_d = '0;
         wr_d  = '0;
         rd_d  = '0;
         lvl_d = '0;
         ovf_d = 1'b0;
      end else begin
         if (in_valid) begin
            acc_d = blk_done ? '0 : acc_nx;
            cnt_d = cnt_q + 1'b1;
         end
         if (push) wr_d = wr_q + 1'b1;
         if (pop)  rd_d = rd_q + 1'b1;
         if (push && !pop)      lvl_d = lvl_q + LW'(1);
         else if (pop && !push) lvl_d = lvl_q - LW'(1);
         if (blk_done && full && !pop) ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q <= '0;
         cnt_q <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         lvl_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         lvl_q <= lvl_d;
         ovf_q <= ovf_d;
      end
   end

   // When full with a simultaneous pop, wr_q equals rd_q: the head leaves as the new tail lands.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_q] <= DW'(sum >> DEC_LOG2);
   end

   assign out_valid  = (lvl_q != '0);
   assign dout       = out_valid ? mem[rd_q] : '0;
   assign fifo_level = lvl_q;
   assign ovf        = ovf_q;
endmodule

// File: tb/tb_fir_out_decim.sv
// Self-checking bench for fir_out_decim: directed tables/sequences plus random traffic vs a queue model.
module tb_fir_out_decim;
   localparam int DEC   = 4;
   localparam int DEPTH = 4;
`ifdef FIR_OUT_DECIM_ROUND_EN
   localparam int RND = 2;
   localparam bit RMODE = 1'b1;
`else
   localparam int RND = 0;
   localparam bit RMODE = 1'b0;
`endif

   logic        clk = 1'b0, rst = 1'b0, in_valid = 1'b0, clr = 1'b0, out_ready = 1'b0;
   logic [15:0] din = '0;
   logic        out_valid, ovf;
   logic [15:0] dout;
   logic [2:0]  fifo_level;

   fir_out_decim #(.DW(16), .DEC_LOG2(2), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .din(din), .clr(clr),
      .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
      .fifo_level(fifo_level), .ovf(ovf)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   int blk[$];
   int q[$];
   bit movf = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      blk.delete();
      q.delete();
      movf = 1'b0;
   endtask

   task automatic model_update(input bit iv, input int d, input bit c, input bit rdy);
      bit pop, push;
      int sum, res;
      if (c) begin
         model_clear();
         return;
      end
      pop  = (q.size() > 0) && rdy;
      push = 1'b0;
      res  = 0;
      if (iv) begin
         blk.push_back(d);
         if (blk.size() == DEC) begin
            sum = 0;
            foreach (blk[i]) sum += blk[i];
            res  = (sum + RND) / DEC;
            push = 1'b1;
            blk.delete();
         end
      end
      if (pop) void'(q.pop_front());
      if (push) begin
         if (q.size() < DEPTH) q.push_back(res);
         else movf = 1'b1;
      end
   endtask

   task automatic check_outputs();
      chk("out_valid", int'(out_valid), (q.size() > 0) ? 1 : 0);
      chk("dout", int'(dout), (q.size() > 0) ? q[0] : 0);
      chk("fifo_level", int'(fifo_level), q.size());
      chk("ovf", int'(ovf), int'(movf));
   endtask

   task automatic step(input bit iv, input int d, input bit c, input bit rdy);
      in_valid  = iv;
      din       = d[15:0];
      clr       = c;
      out_ready = rdy;
      @(posedge clk);
      #1;
      model_update(iv, d, c, rdy);
      check_outputs();
   endtask

   typedef struct {
      int s0, s1, s2, s3;
      int exp_trunc, exp_rnd;
   } vec_t;

   vec_t tbl[5];

   initial begin
      tbl[0] = '{10, 20, 30, 42, 25, 26};
      tbl[1] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
      tbl[2] = '{0, 0, 0, 1, 0, 0};
      tbl[3] = '{0, 0, 1, 1, 0, 1};
      tbl[4] = '{1, 2, 3, 5, 2, 3};

      // reset state
      #12;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_dout", int'(dout), 0);
      chk("rst_level", int'(fifo_level), 0);
      chk("rst_ovf", int'(ovf), 0);
      @(negedge clk);
      rst = 1'b1;

      // table: one block per row, result checked against a fixed constant
      foreach (tbl[r]) begin
         step(1, tbl[r].s0, 0, 0);
         step(1, tbl[r].s1, 0, 0);
         step(1, tbl[r].s2, 0, 0);
         chk("tbl_pre_valid", int'(out_valid), 0);
         step(1, tbl[r].s3, 0, 0);
         chk("tbl_latency", int'(out_valid), 1);
         chk("tbl_dout", int'(dout), RMODE ? tbl[r].exp_rnd : tbl[r].exp_trunc);
         chk("tbl_ovf", int'(ovf), 0);
         step(0, 0, 0, 1);
      end

      // overflow: 5 blocks with consumer stalled, then drain
      step(0, 0, 1, 0);
      for (int k = 1; k <= 5; k++)
         for (int j = 0; j < DEC; j++) step(1, k, 0, 0);
      chk("ovf_level", int'(fifo_level), 4);
      chk("ovf_flag", int'(ovf), 1);
      for (int k = 1; k <= 4; k++) begin
         chk("drain_dout", int'(dout), k);
         step(0, 0, 0, 1);
      end
      chk("drain_level", int'(fifo_level), 0);
      chk("drain_ovf", int'(ovf), 1);

      // full FIFO with push and pop on the same edge
      step(0, 0, 1, 0);
      for (int k = 7; k <= 10; k++)
         for (int j = 0; j < DEC; j++) step(1, k, 0, 0);
      for (int j = 0; j < DEC - 1; j++) step(1, 11, 0, 0);
      step(1, 11, 0, 1);
      chk("pp_level", int'(fifo_level), 4);
      chk("pp_ovf", int'(ovf), 0);
      for (int k = 8; k <= 11; k++) begin
         chk("pp_dout", int'(dout), k);
         step(0, 0, 0, 1);
      end

      // clr on the 2nd sample of a block
      step(1, 50, 0, 0);
      step(1, 60, 1, 0);
      chk("clr_level", int'(fifo_level), 0);
      chk("clr_ovf", int'(ovf), 0);
      step(1, 100, 0, 0);
      step(1, 100, 0, 0);
      step(1, 100, 0, 0);
      chk("clr_pre_valid", int'(out_valid), 0);
      step(1, 104, 0, 0);
      chk("clr_dout", int'(dout), 101);
      step(0, 0, 0, 1);

      // async reset mid-block with two results queued
      for (int j = 0; j < 2 * DEC; j++) step(1, 200 + j, 0, 0);
      step(1, 5, 0, 0);
      chk("pre_rst_level", int'(fifo_level), 2);
      rst = 1'b0;
      #1;
      model_clear();
      chk("arst_valid", int'(out_valid), 0);
      chk("arst_dout", int'(dout), 0);
      chk("arst_level", int'(fifo_level), 0);
      chk("arst_ovf", int'(ovf), 0);
      rst = 1'b1;
      step(1, 40, 0, 0);
      step(1, 40, 0, 0);
      step(1, 40, 0, 0);
      chk("post_rst_partial", int'(out_valid), 0);
      step(1, 40, 0, 0);
      chk("post_rst_dout", int'(dout), 40);
      step(0, 0, 0, 1);

      // random traffic
      for (int n = 0; n < 1500; n++) begin
         step($urandom_range(0, 3) != 0, int'($urandom_range(0, 16'hFFFF)),
              $urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
